// File: rtl/mul_pkg.sv
// Shared encodings for the multiplier request controller: op codes, signedness
// codes, controller states, timeout length and result-selection helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // mul_signed codes: bit 1 = multiplicand signed, bit 0 = multiplier signed
    localparam logic [1:0] SIGN_SS = 2'b11;
    localparam logic [1:0] SIGN_SU = 2'b10;
    localparam logic [1:0] SIGN_UU = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    localparam int unsigned TIMEOUT_CYCLES = 96;
    localparam int unsigned CNT_W          = 7;

    function automatic logic [1:0] op_to_signed(input logic [1:0] op);
        logic [1:0] s;
        case (op)
            OP_MULHSU: s = SIGN_SU;
            OP_MULHU:  s = SIGN_UU;
            default:   s = SIGN_SS;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] select_result(input logic [1:0]   op,
                                                  input logic         word,
                                                  input logic [127:0] prod);
        logic [63:0] r;
        if (word)
            r = {{32{prod[31]}}, prod[31:0]};
        else if (op == OP_MUL)
            r = prod[63:0];
        else
            r = prod[127:64];
        return r;
    endfunction

endpackage

// File: rtl/mul_prod_cache.sv
// One-entry cache of the last full-width product, keyed by operands and
// signedness, so a repeated request can skip the multiplier.
module mul_prod_cache
    import mul_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  lookup_src1,
    input  logic [63:0]  lookup_src2,
    input  logic [1:0]   lookup_signed,
    input  logic         lookup_any_sign,
    input  logic         lookup_word,
    output logic         hit,
    output logic [127:0] hit_product,
    input  logic         wr_en,
    input  logic [63:0]  wr_src1,
    input  logic [63:0]  wr_src2,
    input  logic [1:0]   wr_signed,
    input  logic [127:0] wr_product,
    input  logic         invalidate
);

    logic         valid;
    logic [63:0]  c_src1;
    logic [63:0]  c_src2;
    logic [1:0]   c_signed;
    logic [127:0] c_product;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid     <= 1'b0;
            c_src1    <= '0;
            c_src2    <= '0;
            c_signed  <= '0;
            c_product <= '0;
        end else if (invalidate) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid     <= 1'b1;
            c_src1    <= wr_src1;
            c_src2    <= wr_src2;
            c_signed  <= wr_signed;
            c_product <= wr_product;
        end
    end

    // The low half of a product is the same for any signedness, so MUL hits
    // regardless of how the cached entry was computed.
    always_comb begin
        hit = valid & ~lookup_word
            & (lookup_src1 == c_src1) & (lookup_src2 == c_src2)
            & (lookup_any_sign | (lookup_signed == c_signed));
        hit_product = c_product;
    end

endmodule

// File: rtl/mul_ctrl.sv
// Request controller for an external 64x64 multiplier: issues operations,
// selects the result half, caches the last product and times out stalls.
module mul_ctrl
    import mul_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_word,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        err,
    output logic        mul_in_valid,
    output logic        mul_flush,
    output logic        mul_mulw,
    output logic [1:0]  mul_signed,
    output logic [63:0] mul_multiplicand,
    output logic [63:0] mul_multiplier,
    input  logic        mul_out_ready,
    input  logic        mul_out_valid,
    input  logic [63:0] mul_result_hi,
    input  logic [63:0] mul_result_lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mul_state_e       state;
    logic [1:0]       lat_op;
    logic             lat_word;
    logic [63:0]      lat_src1;
    logic [63:0]      lat_src2;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             req_eff_word;
    logic             timed_out;
    logic             cache_hit;
    logic [127:0]     cache_product;
    logic             cache_wr;
    logic             cache_inval;
    logic [127:0]     mul_product;

    always_comb begin
        req_ready        = (state == ST_IDLE) & ~flush;
        accept           = req_valid & req_ready;
        req_eff_word     = req_word & (req_op == OP_MUL);
        mul_in_valid     = (state == ST_ISSUE) & mul_out_ready & ~flush;
        mul_flush        = flush;
        mul_mulw         = lat_word;
        mul_signed       = op_to_signed(lat_op);
        mul_multiplicand = lat_src1;
        mul_multiplier   = lat_src2;
        mul_product      = {mul_result_hi, mul_result_lo};
        timed_out        = (cnt == CNT_LAST);
    end

    // Cache side effects mirror the WAIT/DRAIN priorities in the FSM below:
    // flush beats a result, a result beats the timeout.
    always_comb begin
        cache_wr    = 1'b0;
        cache_inval = 1'b0;
        case (state)
            ST_WAIT: begin
                cache_wr    = ~flush & mul_out_valid & ~lat_word;
                cache_inval = ~flush & ~mul_out_valid & timed_out;
            end
            ST_DRAIN: cache_inval = ~mul_out_valid & timed_out;
            default: ;
        endcase
    end

    mul_prod_cache u_cache (
        .clock           (clock),
        .reset           (reset),
        .lookup_src1     (req_src1),
        .lookup_src2     (req_src2),
        .lookup_signed   (op_to_signed(req_op)),
        .lookup_any_sign (req_op == OP_MUL),
        .lookup_word     (req_eff_word),
        .hit             (cache_hit),
        .hit_product     (cache_product),
        .wr_en           (cache_wr),
        .wr_src1         (lat_src1),
        .wr_src2         (lat_src2),
        .wr_signed       (mul_signed),
        .wr_product      (mul_product),
        .invalidate      (cache_inval)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_op     <= '0;
            lat_word   <= 1'b0;
            lat_src1   <= '0;
            lat_src2   <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_op   <= req_op;
                        lat_word <= req_eff_word;
                        lat_src1 <= req_src1;
                        lat_src2 <= req_src2;
                        if (cache_hit) begin
                            resp_data  <= select_result(req_op, req_eff_word, cache_product);
                            resp_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (mul_out_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else if (mul_out_valid) begin
                        resp_data  <= select_result(lat_op, lat_word, mul_product);
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (flush || resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mul_out_valid) begin
                        state <= ST_IDLE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  clock; reset  in  1  reset, synchronous, active-high; all state changes on rising edge of clock.
REQ-002 SHALL have upstream ports: req_valid in 1; req_ready out 1; req_op in 2 (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU); req_word in 1 (MULW, valid only with op 00); req_src1 in 64 (rs1); req_src2 in 64 (rs2); flush in 1 (cancel in-flight op).
REQ-003 SHALL have downstream ports: resp_valid out 1; resp_ready in 1; resp_data out 64; err out 1 (one-cycle timeout pulse).
REQ-004 SHALL have multiplier-side ports: mul_in_valid out 1; mul_flush out 1; mul_mulw out 1; mul_signed out 2; mul_multiplicand out 64; mul_multiplier out 64; mul_out_ready in 1; mul_out_valid in 1 (one-cycle pulse); mul_result_hi in 64; mul_result_lo in 64.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-006 SHALL drive req_ready = (state==IDLE) & ~flush; acceptance = req_valid & req_ready; op, word, src1, src2 latched on acceptance.
REQ-007 SHALL map ops: MUL/MULH mul_signed=11; MULHSU 10 (multiplicand=src1 signed, multiplier=src2 unsigned); MULHU 00; MULW 11 with mul_mulw=1; multiplicand=src1, multiplier=src2 always.
REQ-008 SHALL, on accepted miss, go IDLE->ISSUE; in ISSUE assert mul_in_valid only while mul_out_ready=1; cycle with mul_in_valid & mul_out_ready -> WAIT; mul_in_valid low in all other states/cycles.
REQ-009 SHALL, in WAIT, on mul_out_valid capture {hi,lo} -> DONE next cycle; resp_valid=1 exactly in DONE.
REQ-010 SHALL select resp_data: MUL lo; MULH/MULHSU/MULHU hi; MULW sign-extension of lo[31:0].
REQ-011 SHALL hold resp_valid and resp_data stable in DONE until resp_ready=1, then -> IDLE; no back-to-back accept in the DONE->IDLE cycle.
REQ-012 SHALL keep a one-entry product cache: src1, src2, mul_signed, 128-bit product, valid bit; written on every non-word capture in WAIT.
REQ-013 SHALL treat a request as hit when cache valid, req_word=0, src1/src2 equal cached, and (op==MUL or mapped mul_signed equals cached); hit goes IDLE->DONE directly (resp_valid next cycle), multiplier not issued.
REQ-014 SHALL handle flush: IDLE no accept; ISSUE -> IDLE (no mul_in_valid that cycle); WAIT -> DRAIN; DONE -> IDLE, response dropped; DRAIN stays.
REQ-015 SHALL, in DRAIN, discard mul_out_valid result (cache not written) -> IDLE next cycle; mul_flush = flush registered-free passthrough.
REQ-016 SHALL count cycles in WAIT/DRAIN with 7-bit counter cleared on entry; at 96 pulse err, invalidate cache, -> IDLE.
REQ-017 SHALL ignore mul_out_valid outside WAIT/DRAIN.

Reset
REQ-018 SHALL on reset: state IDLE, cache valid 0, counter 0, resp_valid 0, resp_data 0, err 0, mul_in_valid 0, latched operands 0.
REQ-019 SHALL allow reset mid-operation; multiplier is reset on same reset, no drain required.

Structure
REQ-020 SHALL place op encodings, mul_signed codes, FSM state enum and timeout constant (96) in shared package mul_pkg.
REQ-021 SHALL implement cache storage/compare as one sub-module mul_prod_cache; FSM and result select in mul_ctrl.

Verification
REQ-022 SHALL cover: MUL src1=3, src2=0xFFFF_FFFF_FFFF_FFFE -> resp_data 0xFFFF_FFFF_FFFF_FFFA, one mul_in_valid pulse.
REQ-023 SHALL cover: MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> 1; MULH same operands -> 0xFFFF_FFFF_FFFF_FFFF via new issue (signedness differs).
REQ-024 SHALL cover: MULH 5x7 then MUL 5x7 -> second resp_valid 1 cycle after accept, data 35, no mul_in_valid.
REQ-025 SHALL cover: MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-026 SHALL cover: flush 5 cycles into WAIT -> DRAIN, no resp_valid, next MUL 2x3 -> 6, cache unchanged.
REQ-027 SHALL cover: resp_ready held 0 for 10 cycles in DONE -> resp_data stable, req_ready 0; mul_out_valid never asserted -> err pulse after 96 cycles.
